pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. Drives the enable/flush pair of each inter-stage register (F2D, D2E, E2M, M2W) and the PC enable/redirect. Resolves memory waits, load-use hazards, multi-cycle MDU ops and EX-stage redirects. Holds a pending redirect across an outstanding instruction fetch.

Parameters:
XLEN, 64, PC/target width
MDU_LAT, 8, MDU latency in cycles (>=2)
PERF_W, 32, width of perf counters (optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
imem_wait  in  1  fetch outstanding, IF result not valid
dmem_wait  in  1  MEM-stage access outstanding
id_rs1, id_rs2  in  5 each  ID source registers
ex_rd  in  5  EX destination register
ex_is_load  in  1  EX holds a load
ex_muldiv  in  1  EX holds a valid mul/div
ex_redirect  in  1  EX branch/jump mispredict
ex_target  in  XLEN  redirect target
pc_en  out  1  PC register enable
pc_redirect  out  1  select pc_target as next PC
pc_target  out  XLEN  next PC on redirect
f2d_en, d2e_en, e2m_en, m2w_en  out  1 each  stage register enable (0 = stall/hold)
f2d_flush, d2e_flush, e2m_flush, m2w_flush  out  1 each  load bubble (only meaningful with en=1)
mdu_done  out  1  MDU result valid this cycle
perf_mem, perf_mdu, perf_lu, perf_if  out  PERF_W each  stall-cycle counters

Behaviour:
- Combinational outputs derived from inputs plus registered state (redirect FSM, MDU FSM/counter). Every flush is asserted only together with its en=1.
- Priority (highest first):
  1. dmem_wait: m2w en=1 flush=1; E2M/D2E/F2D/PC en=0.
  2. mdu_stall (ex_muldiv && MDU not DONE): e2m en=1 flush=1; D2E/F2D/PC en=0; M2W advances.
  3. ex_redirect, or pending redirect issuing: F2D and D2E flush; PC loads target. Overrides load-use.
  4. load_use (ex_is_load && ex_rd!=0 && ex_rd in {id_rs1,id_rs2}): d2e en=1 flush=1; F2D/PC en=0.
  5. imem_wait: f2d en=1 flush=1; pc_en=0.
- ex_redirect sampled only when EX is not stalled (levels 1-2 inactive).
- Redirect FSM:
  - RD_IDLE: redirect with imem_wait=0 → pc_redirect=1, pc_en=1, pc_target=ex_target.
  - Redirect with imem_wait=1 → latch target, go RD_PEND; F2D/D2E flushed this cycle.
  - RD_PEND: f2d en=1 flush=1 each cycle. When imem_wait=0, the returned instruction is discarded (F2D flushed), pc_redirect=1 with latched target, back to RD_IDLE. A new ex_redirect in RD_PEND overwrites the target.
- MDU FSM (IDLE/BUSY/DONE, counter width $clog2(MDU_LAT+1)):
  - IDLE with ex_muldiv → BUSY, count=MDU_LAT-1, stalls.
  - BUSY: decrement each cycle (keeps counting during dmem_wait); at 1 → DONE.
  - DONE: mdu_done=1, no mdu stall. Leave to IDLE when e2m_en=1.
  - Net: a muldiv occupies EX for exactly MDU_LAT cycles with no other stall. Back-to-back muldivs restart from IDLE.
- Reset: RD_IDLE, MDU IDLE, counters 0. During reset all en=1, flush=1, pc_redirect=0. Reset mid-operation discards pending target and MDU progress.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: four PERF_W counters, saturating, increment on cycles where that cause is the winning stall (mem, mdu, load-use, imem incl. RD_PEND). Cleared on reset.
- Undefined: counters absent; perf_* tied to 0.

Decomposition:
- Package pipes:
  - typedef stage_ctrl_t {en, flush}
  - enums rd_state_t {RD_IDLE, RD_PEND} and mdu_state_t {MDU_IDLE, MDU_BUSY, MDU_DONE}
  - constant REG_ZERO=5'd0
- Sub-module mdu_timer: the MDU FSM + counter. Inputs: start, advance. Outputs: stall, done.

Test Plan:
- ex_is_load=1, ex_rd=5, id_rs1=5, no waits → d2e en=1 flush=1, f2d_en=0, pc_en=0 for 1 cycle. Repeat with ex_rd=0 → no stall.
- ex_muldiv held, MDU_LAT=8 → e2m flush for cycles 1-7, mdu_done=1 on cycle 8 with e2m_en=1 flush=0, then MDU_IDLE.
- ex_redirect target 0x8000_0040 with imem_wait=1 for 3 more cycles → RD_PEND. f2d flushed for 4 cycles; pc_redirect=1, pc_target=0x8000_0040 on the cycle imem_wait falls.
- dmem_wait=1 coincident with ex_redirect and load_use → only m2w flush; all else held, redirect not taken. Redirect taken the cycle after dmem_wait drops.
- Reset asserted while MDU BUSY (count 4) and RD_PEND → next cycle both FSMs idle, no pc_redirect, muldiv restarts full MDU_LAT.
- With PIPE_CTRL_PERF_EN, 3 dmem_wait cycles plus 2 load-use cycles → perf_mem=3, perf_lu=2, others 0.

Source files
------------

// File: rtl/pipes.sv
//------------------------------------------------------------------------------
// Module : pipes (package)
// Brief  : Shared types and constants for the pipeline hazard controller.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipes;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_PEND = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam stage_ctrl_t STAGE_RUN    = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t STAGE_HOLD   = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t STAGE_BUBBLE = '{en: 1'b1, flush: 1'b1};

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_mdu_timer.sv
//------------------------------------------------------------------------------
// Module : pipe_ctrl_mdu_timer
// Brief  : Multi-cycle MDU occupancy timer; holds EX for exactly MDU_LAT cycles.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl_mdu_timer
  import pipes::*;
#(
  parameter int MDU_LAT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic advance,
  output logic stall,
  output logic done
);

  localparam int              CNT_W   = $clog2(MDU_LAT + 1);
  localparam logic [CNT_W-1:0] C_START = CNT_W'(MDU_LAT - 1);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          cnt_d   = C_START;
          state_d = (MDU_LAT <= 2) ? MDU_DONE : MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        // Keeps counting even while downstream stalls hold EX
        if (!start) begin
          state_d = MDU_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(2)) state_d = MDU_DONE;
        end
      end
      MDU_DONE: begin
        if (advance) state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall = start && (state_q != MDU_DONE);
  assign done  = (state_q == MDU_DONE);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//------------------------------------------------------------------------------
// Module : pipe_ctrl
// Brief  : 5-stage pipeline hazard/sequencing controller (stalls, bubbles,
//          PC redirect, pending redirect across an outstanding fetch).
//          Optional stall-cycle counters enabled by PIPE_CTRL_PERF_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl
  import pipes::*;
#(
  parameter int XLEN    = 64,
  parameter int MDU_LAT = 8,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_wait,
  input  logic              dmem_wait,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_muldiv,
  input  logic              ex_redirect,
  input  logic [XLEN-1:0]   ex_target,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic [XLEN-1:0]   pc_target,
  output logic              f2d_en,
  output logic              d2e_en,
  output logic              e2m_en,
  output logic              m2w_en,
  output logic              f2d_flush,
  output logic              d2e_flush,
  output logic              e2m_flush,
  output logic              m2w_flush,
  output logic              mdu_done,
  output logic [PERF_W-1:0] perf_mem,
  output logic [PERF_W-1:0] perf_mdu,
  output logic [PERF_W-1:0] perf_lu,
  output logic [PERF_W-1:0] perf_if
);

  rd_state_t       rd_state_q, rd_state_d;
  logic [XLEN-1:0] rd_target_q, rd_target_d;

  logic        w_mdu_stall;
  logic        w_mdu_done;
  logic        w_ex_stall;
  logic        w_load_use;
  logic        w_take_redir;
  logic        w_pend_issue;
  stage_ctrl_t w_f2d, w_d2e, w_e2m, w_m2w;

  pipe_ctrl_mdu_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (ex_muldiv),
    .advance (w_e2m.en),
    .stall   (w_mdu_stall),
    .done    (w_mdu_done)
  );

  assign w_ex_stall   = dmem_wait || w_mdu_stall;
  assign w_load_use   = ex_is_load && (ex_rd != REG_ZERO) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign w_take_redir = ex_redirect && !w_ex_stall;
  // A latched redirect can only go out once the fetch has returned
  assign w_pend_issue = (rd_state_q == RD_PEND) && !imem_wait && !w_ex_stall;

  always_comb begin
    w_f2d       = STAGE_RUN;
    w_d2e       = STAGE_RUN;
    w_e2m       = STAGE_RUN;
    w_m2w       = STAGE_RUN;
    pc_en       = 1'b1;
    pc_redirect = 1'b0;
    pc_target   = w_take_redir ? ex_target : rd_target_q;
    if (reset) begin
      w_f2d = STAGE_BUBBLE;
      w_d2e = STAGE_BUBBLE;
      w_e2m = STAGE_BUBBLE;
      w_m2w = STAGE_BUBBLE;
    end else if (dmem_wait) begin
      w_m2w = STAGE_BUBBLE;
      w_e2m = STAGE_HOLD;
      w_d2e = STAGE_HOLD;
      w_f2d = STAGE_HOLD;
      pc_en = 1'b0;
    end else if (w_mdu_stall) begin
      w_e2m = STAGE_BUBBLE;
      w_d2e = STAGE_HOLD;
      w_f2d = STAGE_HOLD;
      pc_en = 1'b0;
    end else if (w_take_redir || w_pend_issue) begin
      w_f2d       = STAGE_BUBBLE;
      w_d2e       = STAGE_BUBBLE;
      pc_en       = !imem_wait;
      pc_redirect = !imem_wait;
    end else if (w_load_use) begin
      w_d2e = STAGE_BUBBLE;
      w_f2d = STAGE_HOLD;
      pc_en = 1'b0;
    end else if (imem_wait) begin
      w_f2d = STAGE_BUBBLE;
      pc_en = 1'b0;
    end
  end

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_target_d = rd_target_q;
    if (w_take_redir && imem_wait) begin
      rd_state_d  = RD_PEND;
      rd_target_d = ex_target;
    end else if (w_take_redir || w_pend_issue) begin
      rd_state_d = RD_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q  <= RD_IDLE;
      rd_target_q <= '0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_target_q <= rd_target_d;
    end
  end

  assign f2d_en    = w_f2d.en;
  assign f2d_flush = w_f2d.flush;
  assign d2e_en    = w_d2e.en;
  assign d2e_flush = w_d2e.flush;
  assign e2m_en    = w_e2m.en;
  assign e2m_flush = w_e2m.flush;
  assign m2w_en    = w_m2w.en;
  assign m2w_flush = w_m2w.flush;
  assign mdu_done  = w_mdu_done && !reset;

`ifdef PIPE_CTRL_PERF_EN
  logic [3:0]             w_win;
  logic [3:0][PERF_W-1:0] perf_q, perf_d;

  // One-hot winning stall cause: mem, mdu, load-use, imem (incl. pending redirect)
  assign w_win[0] = dmem_wait;
  assign w_win[1] = !dmem_wait && w_mdu_stall;
  assign w_win[2] = !w_ex_stall && !w_take_redir && !w_pend_issue && w_load_use;
  assign w_win[3] = !w_ex_stall && !w_take_redir && !w_pend_issue && !w_load_use &&
                    imem_wait;

  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < 4; i++) begin
      if (w_win[i] && (perf_q[i] != {PERF_W{1'b1}})) perf_d[i] = perf_q[i] + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_mem = perf_q[0];
  assign perf_mdu = perf_q[1];
  assign perf_lu  = perf_q[2];
  assign perf_if  = perf_q[3];
`else
  assign perf_mem = '0;
  assign perf_mdu = '0;
  assign perf_lu  = '0;
  assign perf_if  = '0;
`endif

endmodule

`default_nettype wire
